// File: rtl/serial_alu_flags_pkg.sv
// Shared op-codes, flag bit positions and FSM states for the chunk-serial ALU.
// Purely declarative: no latency, no flow control.
package serial_alu_flags_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_MOV = 3'd7
  } alu_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  function automatic logic is_arith(alu_op_e op);
    return op inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC};
  endfunction

  // Carry fed into the least-significant chunk.
  function automatic logic init_carry(alu_op_e op, logic carry);
    case (op)
      ALU_SUB:          return 1'b1;
      ALU_ADC, ALU_SBC: return carry;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] pack_flags(logic n, logic z, logic v, logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/serial_alu_flags_alu_chunk.sv
// One CHUNK-wide ALU slice, purely combinational (zero latency, no flow control).
// Returns the slice result, carry-out and carry into the slice MSB for overflow.
module alu_chunk
  import serial_alu_flags_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK-1:0] bb;

  always_comb begin
    bb   = (op == ALU_SUB || op == ALU_SBC) ? ~b : b;
    sum  = '0;
    cout = 1'b0;
    cmsb = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
        {cout, sum} = {1'b0, a} + {1'b0, bb} + {{CHUNK{1'b0}}, cin};
        // Sum MSB = a ^ b ^ carry-in at that bit, so the carry is recovered.
        cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ bb[CHUNK-1];
      end
      ALU_AND: sum = a & b;
      ALU_OR:  sum = a | b;
      ALU_XOR: sum = a ^ b;
      ALU_MOV: sum = b;
      default: sum = '0;
    endcase
  end

endmodule

// File: rtl/serial_alu_flags.sv
// Chunk-serial ALU producing a result and {N,Z,V,C}; WRITE (done + flags strobe) N+1 cycles after start.
// No backpressure: start_in is taken only in IDLE and dropped while busy. Option: SERIAL_ALU_FAST_LOGIC_EN.
module serial_alu_flags
  import serial_alu_flags_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result_out,
  output logic             flags_cs_out,
  output logic [3:0]       flags_bus_out
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  alu_op_e          op_q;
  logic             carry_q, zero_q;
  logic [3:0]       flags_q;
  logic [CHUNK-1:0] sum;
  logic             cout, cmsb;
  logic             last_run;
  logic             fast_go;

  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .op   (op_q),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );

  assign last_run = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ALU_FAST_LOGIC_EN
  logic [WIDTH-1:0] fast_res;
  assign fast_go = !is_arith(alu_op_e'(op_in));
  always_comb begin
    case (alu_op_e'(op_in))
      ALU_AND: fast_res = a_in & b_in;
      ALU_OR:  fast_res = a_in | b_in;
      ALU_XOR: fast_res = a_in ^ b_in;
      default: fast_res = b_in;
    endcase
  end
`else
  assign fast_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = fast_go ? S_WRITE : S_RUN;
      S_RUN:   if (last_run) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= ALU_ADD;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            op_q    <= alu_op_e'(op_in);
            carry_q <= init_carry(alu_op_e'(op_in), carry_in);
            zero_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef SERIAL_ALU_FAST_LOGIC_EN
            if (fast_go) begin
              res_q   <= fast_res;
              flags_q <= pack_flags(fast_res[WIDTH-1], fast_res == '0, 1'b0, 1'b0);
            end
`endif
          end
        end
        S_RUN: begin
          // Operands shift down so the active chunk is always the low slice.
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          res_q   <= {sum, res_q[WIDTH-1:CHUNK]};
          carry_q <= cout;
          zero_q  <= zero_q & (sum == '0);
          cnt_q   <= cnt_q + CW'(1);
          if (last_run)
            flags_q <= pack_flags(sum[CHUNK-1], zero_q & (sum == '0),
                                  is_arith(op_q) & (cmsb ^ cout),
                                  is_arith(op_q) & cout);
        end
        default: ;
      endcase
    end
  end

  assign busy_out      = (state_q != S_IDLE);
  assign done_out      = (state_q == S_WRITE);
  assign flags_cs_out  = (state_q == S_WRITE);
  assign result_out    = res_q;
  assign flags_bus_out = flags_q;

endmodule

// File: tb/tb_serial_alu_flags.sv
// Bench for serial_alu_flags: vector table, multi-cycle corner sequences and random ops vs. an arithmetic model.
module tb_serial_alu_flags;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [2:0]  op_in;
  logic [15:0] a_in, b_in;
  logic        carry_in;
  logic        busy_out, done_out, flags_cs_out;
  logic [15:0] result_out;
  logic [3:0]  flags_bus_out;

  int errors = 0;
  int checks = 0;

  serial_alu_flags #(.WIDTH(16), .CHUNK(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .op_in         (op_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .carry_in      (carry_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .result_out    (result_out),
    .flags_cs_out  (flags_cs_out),
    .flags_bus_out (flags_bus_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op);
`ifdef SERIAL_ALU_FAST_LOGIC_EN
    if (op >= 3'd4) return 1;
`endif
    return 5;
  endfunction

  // Reference: unsigned sum for carry, signed sum for overflow.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [15:0] bb, r;
    int          ci, us, ss;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    r = 16'h0;
    if (op < 3'd4) begin
      bb = (op == 3'd2 || op == 3'd3) ? ~b : b;
      case (op)
        3'd0:    ci = 0;
        3'd2:    ci = 1;
        default: ci = int'(cin);
      endcase
      us = int'(a) + int'(bb) + ci;
      ss = int'($signed(a)) + int'($signed(bb)) + ci;
      r  = us[15:0];
      c  = (us > 65535);
      v  = (ss > 32767) || (ss < -32768);
    end else begin
      case (op)
        3'd4:    r = a & b;
        3'd5:    r = a | b;
        3'd6:    r = a ^ b;
        default: r = b;
      endcase
    end
    return {r[15], (r == 16'h0), v, c, r};
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic [15:0] eres,
                        input logic [3:0] eflags, input int restart_at, input int rst_at);
    int          w, lim, done_cyc, cs_cnt, cs_cyc, busy_bad;
    logic        exp_busy;
    logic [15:0] res_w;
    logic [3:0]  fl_w, fl_after;
    w        = exp_lat(op);
    lim      = (rst_at > 0) ? w + 3 : w + 1;
    done_cyc = 0;
    cs_cnt   = 0;
    cs_cyc   = 0;
    busy_bad = 0;
    res_w    = 16'hdead;
    fl_w     = 4'hf;
    fl_after = 4'hf;
    @(negedge clk);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    carry_in = cin;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk);
      #1;
      exp_busy = (rst_at > 0) ? (c <= rst_at) : (c <= w);
      if (busy_out !== exp_busy) busy_bad++;
      if (done_out === 1'b1) done_cyc = c;
      if (flags_cs_out === 1'b1) begin
        cs_cnt++;
        cs_cyc = c;
      end
      if (c == w || (rst_at > 0 && c == rst_at + 1)) begin
        res_w = result_out;
        fl_w  = flags_bus_out;
      end
      if (c == w + 1) fl_after = flags_bus_out;
      // Scramble operands after accept; a correct design has latched them.
      a_in     = ~a;
      b_in     = b ^ 16'h5a5a;
      carry_in = ~cin;
      start_in = (c == restart_at);
      rst      = (c == rst_at);
    end
    start_in = 1'b0;
    rst      = 1'b0;
    chk({name, " busy profile errors"}, busy_bad, 0);
    if (rst_at > 0) begin
      chk({name, " strobes after rst"}, cs_cnt, 0);
      chk({name, " done after rst"}, done_cyc, 0);
      chk({name, " result after rst"}, {16'h0, res_w}, 0);
      chk({name, " flags after rst"}, {28'h0, fl_w}, 0);
    end else begin
      chk({name, " done cycle"}, done_cyc, w);
      chk({name, " strobe count"}, cs_cnt, 1);
      chk({name, " strobe cycle"}, cs_cyc, w);
      chk({name, " result"}, {16'h0, res_w}, {16'h0, eres});
      chk({name, " flags"}, {28'h0, fl_w}, {28'h0, eflags});
      chk({name, " flags held"}, {28'h0, fl_after}, {28'h0, eflags});
    end
  endtask

  initial begin
    logic [19:0] m;
    logic [2:0]  rop;
    logic [15:0] ra, rb;
    logic        rc;

    vecs[0] = '{3'd0, 16'h7fff, 16'h0001, 1'b0, 16'h8000, 4'b1010};
    vecs[1] = '{3'd2, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0101};
    vecs[2] = '{3'd1, 16'hffff, 16'h0000, 1'b1, 16'h0000, 4'b0101};
    vecs[3] = '{3'd3, 16'h0000, 16'h0001, 1'b1, 16'hffff, 4'b1000};
    vecs[4] = '{3'd6, 16'hf0f0, 16'hf0f0, 1'b0, 16'h0000, 4'b0100};
    vecs[5] = '{3'd2, 16'h0003, 16'h0005, 1'b1, 16'hfffe, 4'b1000};
    vecs[6] = '{3'd2, 16'h8000, 16'h0001, 1'b0, 16'h7fff, 4'b0011};
    vecs[7] = '{3'd5, 16'h1200, 16'h0034, 1'b1, 16'h1234, 4'b0000};
    vecs[8] = '{3'd7, 16'h1111, 16'h8001, 1'b1, 16'h8001, 4'b1000};
    vecs[9] = '{3'd4, 16'hff00, 16'h00ff, 1'b0, 16'h0000, 4'b0100};

    rst      = 1'b1;
    start_in = 1'b0;
    op_in    = 3'd0;
    a_in     = 16'h0;
    b_in     = 16'h0;
    carry_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'h0, busy_out}, 0);
    chk("reset done", {31'h0, done_out}, 0);
    chk("reset strobe", {31'h0, flags_cs_out}, 0);
    chk("reset result", {16'h0, result_out}, 0);
    chk("reset flags", {28'h0, flags_bus_out}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].res, vecs[i].flags, 0, 0);

    // Second start mid-operation must be dropped, not queued.
    run_op("restart ignored", 3'd0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 4'b0000, 2, 0);

    // Reset mid-RUN: no strobe, then a clean operation afterwards.
    run_op("rst mid run", 3'd0, 16'h1234, 16'h1111, 1'b0, 16'h0, 4'h0, 0, 2);
    run_op("after rst", 3'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000, 0, 0);

    // rst and start together: rst wins and the start is not remembered.
    @(negedge clk);
    rst      = 1'b1;
    start_in = 1'b1;
    op_in    = 3'd0;
    @(posedge clk);
    #1;
    chk("rst+start busy", {31'h0, busy_out}, 0);
    rst      = 1'b0;
    start_in = 1'b0;
    @(posedge clk);
    #1;
    chk("rst+start not queued", {31'h0, busy_out}, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = (i % 5 == 0) ? ra : 16'($urandom);
      rc  = 1'($urandom_range(0, 1));
      m   = model(rop, ra, rb, rc);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rc, m[15:0], m[19:16], 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
